// File: rtl/run_limit_serializer.sv
// run_limit_serializer: MSB-first word serialiser that inserts a complementary
// stuff bit after every MAX_RUN identical consecutive line bits.
// Optional build macro: RLS_STATS_EN enables the 16-bit stuffed-bit counter
// on stuff_cnt_o. Without it, stuff_cnt_o is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line quiet, tx_valid low, run cleared, ready for a word
// S_SHIFT | a data bit of the current word is on the line
// S_STUFF | a stuffed (complement of previous) bit is on the line
//
// All line registers describe the bit that is on the line in the current
// cycle. That bit is launched on the edge that enters the cycle. run_q and
// last_q already include that bit.
module run_limit_serializer #(
    parameter int W       = 8,
    parameter int MAX_RUN = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         tx_bit_o,
    output logic         tx_valid_o,
    output logic         tx_stuff_o,
    output logic         busy_o,
    output logic [15:0]  stuff_cnt_o
);

    localparam int IW = $clog2(W);
    localparam int RW = $clog2(MAX_RUN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_STUFF = 2'd2;

    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_RUN);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [RW-1:0] run_q,   run_d;
    logic          last_q,  last_d;
    logic          bit_q,   bit_d;

    logic word_end;
    logic ready;
    logic accept;
    logic fin;
    logic step;
    logic ld_data;
    logic nb;

    // Final line cycle of a word: last data bit with no stuff pending, or the
    // trailing stuff after the last data bit (idx is kept at 0 through it).
    always_comb begin
        word_end = ((state_q == S_SHIFT) && (idx_q == '0) && (run_q != RUN_MAX)) ||
                   ((state_q == S_STUFF) && (idx_q == '0));
        ready    = !rst && ((state_q == S_IDLE) || word_end);
        accept   = in_valid_i && ready;
    end

    // Next-state: pick the next line bit and update the run tracker for it.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        run_d   = run_q;
        last_d  = last_q;
        bit_d   = bit_q;
        fin     = 1'b0;
        step    = 1'b0;
        ld_data = 1'b0;
        nb      = 1'b0;

        case (state_q)
            S_IDLE: begin
                run_d = '0;
            end
            S_SHIFT: begin
                if (run_q == RUN_MAX) begin
                    state_d = S_STUFF;
                    bit_d   = ~last_q;
                    last_d  = ~last_q;
                    run_d   = RUN_ONE;
                end else if (idx_q == '0) begin
                    fin = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            S_STUFF: begin
                if (idx_q == '0) begin
                    fin = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                run_d   = '0;
            end
        endcase

        if (accept) begin
            shreg_d = in_data_i;
            idx_d   = IW'(W - 1);
            nb      = in_data_i[W-1];
            ld_data = 1'b1;
        end else if (fin) begin
            state_d = S_IDLE;
            run_d   = '0;
            bit_d   = 1'b0;
        end else if (step) begin
            idx_d   = idx_q - 1'b1;
            nb      = shreg_q[idx_d];
            ld_data = 1'b1;
        end

        // A run continues only if the previous line bit was live (run != 0).
        if (ld_data) begin
            state_d = S_SHIFT;
            bit_d   = nb;
            last_d  = nb;
            run_d   = ((nb == last_q) && (run_q != '0)) ? run_q + 1'b1 : RUN_ONE;
        end
    end

    // Line state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
        end
    end

`ifdef RLS_STATS_EN
    logic [15:0] scnt_q;

    // Count every stuff cycle; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= '0;
        end else if (state_q == S_STUFF) begin
            scnt_q <= scnt_q + 16'd1;
        end
    end

    assign stuff_cnt_o = scnt_q;
`else
    assign stuff_cnt_o = 16'd0;
`endif

    assign in_ready_o = ready;
    assign tx_bit_o   = bit_q;
    assign tx_valid_o = (state_q != S_IDLE);
    assign tx_stuff_o = (state_q == S_STUFF);
    assign busy_o     = (state_q != S_IDLE);

endmodule
